// File: rtl/conv_enc_pkg.sv
// Shared types, default generator polynomials and the parity helper
// used by the parametrised convolutional encoder.
package conv_enc_pkg;

    localparam int unsigned K_MAX = 9;

    localparam logic [2:0] G_7 = 3'b111;
    localparam logic [2:0] G_5 = 3'b101;

    typedef enum logic {RUN, TAIL} enc_state_t;

    function automatic logic poly_xor(input logic [K_MAX-1:0] g, input logic [K_MAX-1:0] v);
        return ^(g & v);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational trellis step: from the shift register and the input source,
// produce the register input x, the coded pair and the next register value.
module conv_enc_core
    import conv_enc_pkg::*;
#(
    parameter int unsigned  K         = 3,
    parameter logic [K-1:0] G0        = K'(G_7),
    parameter logic [K-1:0] G1        = K'(G_5),
    parameter bit           RECURSIVE = 1'b0
) (
    input  logic [K-2:0] i_r,
    input  logic         i_data,
    input  logic         i_tail,
    output logic         o_x,
    output logic [1:0]   o_code,
    output logic [K-2:0] o_r_next
);

    logic w_fb;
    logic w_u;

    // Tail input is chosen so that x is always 0, driving the trellis to zero.
    always_comb begin
        w_fb = poly_xor(K_MAX'(G0) & ~K_MAX'(1), K_MAX'({i_r, 1'b0}));
        if (RECURSIVE) begin
            w_u    = i_tail ? w_fb : i_data;
            o_x    = w_u ^ w_fb;
            o_code = {w_u, poly_xor(K_MAX'(G1), K_MAX'({i_r, o_x}))};
        end else begin
            w_u    = i_tail ? 1'b0 : i_data;
            o_x    = w_u;
            o_code = {poly_xor(K_MAX'(G0), K_MAX'({i_r, o_x})),
                      poly_xor(K_MAX'(G1), K_MAX'({i_r, o_x}))};
        end
    end

    assign o_r_next = {i_r[K-3:0], o_x};

endmodule

// File: rtl/conv_encoder_param.sv
// Rate-1/2 convolutional encoder (feedforward or RSC) with optional zero-state
// tail flush, valid/ready on both sides and frame delimiting via last.
module conv_encoder_param
    import conv_enc_pkg::*;
#(
    parameter int unsigned  K         = 3,
    parameter logic [K-1:0] G0        = K'(G_7),
    parameter logic [K-1:0] G1        = K'(G_5),
    parameter bit           RECURSIVE = 1'b0,
    parameter bit           TERMINATE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_data,
    output logic       out_last
);

    localparam int unsigned     CNT_W    = $clog2(K);
    localparam logic [CNT_W-1:0] TAIL_END = CNT_W'(K - 2);

    if (K < 3 || K > K_MAX) begin : g_bad_k
        $fatal(1, "conv_encoder_param: K out of range 3..9");
    end
    if (RECURSIVE && !G0[0]) begin : g_bad_g0
        $fatal(1, "conv_encoder_param: RSC mode needs G0[0]=1");
    end

    enc_state_t       r_state, w_state_n;
    logic [K-2:0]     r_sreg, w_sreg_n;
    logic [CNT_W-1:0] r_tail_cnt, w_tail_cnt_n;
    logic             r_out_valid, w_out_valid_n;
    logic [1:0]       r_out_data, w_out_data_n;
    logic             r_out_last, w_out_last_n;

    logic             w_adv;
    logic             w_x;
    logic [1:0]       w_code;
    logic [K-2:0]     w_r_next;

    conv_enc_core #(
        .K         (K),
        .G0        (G0),
        .G1        (G1),
        .RECURSIVE (RECURSIVE)
    ) u_core (
        .i_r      (r_sreg),
        .i_data   (in_data),
        .i_tail   (r_state == TAIL),
        .o_x      (w_x),
        .o_code   (w_code),
        .o_r_next (w_r_next)
    );

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = (r_state == RUN) && w_adv;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_sreg      <= '0;
            r_tail_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 2'b00;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_sreg      <= w_sreg_n;
            r_tail_cnt  <= w_tail_cnt_n;
            r_out_valid <= w_out_valid_n;
            r_out_data  <= w_out_data_n;
            r_out_last  <= w_out_last_n;
        end
    end

    // Next-state and output-register load; nothing moves unless the output slot frees up.
    always_comb begin
        w_state_n     = r_state;
        w_sreg_n      = r_sreg;
        w_tail_cnt_n  = r_tail_cnt;
        w_out_valid_n = r_out_valid;
        w_out_data_n  = r_out_data;
        w_out_last_n  = r_out_last;
        case (r_state)
            RUN: begin
                if (w_adv) begin
                    if (in_valid) begin
                        w_out_valid_n = 1'b1;
                        w_out_data_n  = w_code;
                        w_out_last_n  = 1'b0;
                        w_sreg_n      = w_r_next;
                        if (in_last) begin
                            if (TERMINATE) begin
                                w_state_n    = TAIL;
                                w_tail_cnt_n = '0;
                            end else begin
                                w_out_last_n = 1'b1;
                                w_sreg_n     = '0;
                            end
                        end
                    end else begin
                        w_out_valid_n = 1'b0;
                        w_out_last_n  = 1'b0;
                    end
                end
            end
            TAIL: begin
                if (w_adv) begin
                    w_out_valid_n = 1'b1;
                    w_out_data_n  = w_code;
                    w_tail_cnt_n  = r_tail_cnt + CNT_W'(1);
                    w_sreg_n      = w_r_next;
                    w_out_last_n  = 1'b0;
                    if (r_tail_cnt == TAIL_END) begin
                        w_out_last_n = 1'b1;
                        w_sreg_n     = '0;
                        w_state_n    = RUN;
                    end
                end
            end
            default: w_state_n = RUN;
        endcase
    end

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed bench for conv_encoder_param: four configurations share one stimulus
// bus; each scenario resets, drives a frame and checks the selected instance.
module tb_conv_encoder_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_data, in_last, out_ready;
    logic [3:0] rdy, vld, lst;
    logic [1:0] dat [4];

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] cap_d [$];
    logic       cap_l [$];
    int         ready_low, stall_low, hold_bad;
    logic [1:0] g_held;

    conv_encoder_param u_ff (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .in_last(in_last), .out_valid(vld[0]), .out_ready(out_ready), .out_data(dat[0]),
        .out_last(lst[0]));

    conv_encoder_param #(.RECURSIVE(1'b1)) u_rsc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .in_last(in_last), .out_valid(vld[1]), .out_ready(out_ready), .out_data(dat[1]),
        .out_last(lst[1]));

    conv_encoder_param #(.TERMINATE(1'b0)) u_noterm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
        .in_last(in_last), .out_valid(vld[2]), .out_ready(out_ready), .out_data(dat[2]),
        .out_last(lst[2]));

    conv_encoder_param #(.K(4), .G0(4'b1011), .G1(4'b1101)) u_k4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data),
        .in_last(in_last), .out_valid(vld[3]), .out_ready(out_ready), .out_data(dat[3]),
        .out_last(lst[3]));

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives a bit stream into instance sel and records every delivered output beat.
    task automatic drive_collect(input int sel, input logic [15:0] bits, input logic [15:0] lasts,
                                 input int n, input int stall_at, input int stall_len,
                                 input int exp_beats);
        int idx = 0;
        int cyc = 0;
        int stall_left = stall_len;
        cap_d.delete(); cap_l.delete();
        ready_low = 0; stall_low = 0; hold_bad = 0; g_held = 2'b00;
        while (cap_d.size() < exp_beats && cyc < 200) begin
            in_valid  = (idx < n);
            in_data   = (idx < n) ? bits[idx[3:0]] : 1'b0;
            in_last   = (idx < n) ? lasts[idx[3:0]] : 1'b0;
            out_ready = 1'b1;
            if (vld[sel] && cap_d.size() == stall_at && stall_left > 0) begin
                if (stall_left == stall_len) g_held = dat[sel];
                else if (dat[sel] !== g_held) hold_bad++;
                out_ready = 1'b0;
                stall_left--;
            end
            #1;
            if (!rdy[sel]) begin
                ready_low++;
                if (!out_ready) stall_low++;
            end
            if (vld[sel] && out_ready) begin
                cap_d.push_back(dat[sel]);
                cap_l.push_back(lst[sel]);
            end
            if (in_valid && rdy[sel]) idx++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (vld[i] !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b want 0", i, vld[i]); end
            n_vec++;
            if (dat[i] !== 2'b00) begin n_err++; $display("FAIL reset_data[%0d]: got %b want 00", i, dat[i]); end
            n_vec++;
            if (lst[i] !== 1'b0) begin n_err++; $display("FAIL reset_last[%0d]: got %b want 0", i, lst[i]); end
            n_vec++;
            if (rdy[i] !== 1'b1) begin n_err++; $display("FAIL reset_ready[%0d]: got %b want 1", i, rdy[i]); end
        end
    endtask

    task automatic test_ff_terminate();
        logic [1:0] exp_d [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        logic [5:0] exp_l = 6'b100000;
        do_reset();
        drive_collect(0, 16'h000D, 16'h0008, 4, -1, 0, 6);
        n_vec++;
        if (cap_d.size() !== 6) begin
            n_err++; $display("FAIL ff_beats: got %0d want 6", cap_d.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (cap_d[i] !== exp_d[i]) begin n_err++; $display("FAIL ff_data[%0d]: got %b want %b", i, cap_d[i], exp_d[i]); end
                n_vec++;
                if (cap_l[i] !== exp_l[i]) begin n_err++; $display("FAIL ff_last[%0d]: got %b want %b", i, cap_l[i], exp_l[i]); end
            end
        end
        n_vec++;
        if (ready_low !== 2) begin n_err++; $display("FAIL ff_tail_ready_low: got %0d want 2", ready_low); end
    endtask

    task automatic test_rsc();
        logic [1:0] exp_d [6] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11};
        logic [5:0] exp_l = 6'b100100;
        do_reset();
        drive_collect(1, 16'h0003, 16'h0003, 2, -1, 0, 6);
        n_vec++;
        if (cap_d.size() !== 6) begin
            n_err++; $display("FAIL rsc_beats: got %0d want 6", cap_d.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (cap_d[i] !== exp_d[i]) begin n_err++; $display("FAIL rsc_data[%0d]: got %b want %b", i, cap_d[i], exp_d[i]); end
                n_vec++;
                if (cap_l[i] !== exp_l[i]) begin n_err++; $display("FAIL rsc_last[%0d]: got %b want %b", i, cap_l[i], exp_l[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] exp_d [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        logic [5:0] exp_l = 6'b100000;
        do_reset();
        drive_collect(0, 16'h000D, 16'h0008, 4, 1, 3, 6);
        n_vec++;
        if (cap_d.size() !== 6) begin
            n_err++; $display("FAIL bp_beats: got %0d want 6", cap_d.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (cap_d[i] !== exp_d[i]) begin n_err++; $display("FAIL bp_data[%0d]: got %b want %b", i, cap_d[i], exp_d[i]); end
                n_vec++;
                if (cap_l[i] !== exp_l[i]) begin n_err++; $display("FAIL bp_last[%0d]: got %b want %b", i, cap_l[i], exp_l[i]); end
            end
        end
        n_vec++;
        if (g_held !== 2'b10) begin n_err++; $display("FAIL bp_held_value: got %b want 10", g_held); end
        n_vec++;
        if (hold_bad !== 0) begin n_err++; $display("FAIL bp_hold_stable: got %0d changes want 0", hold_bad); end
        n_vec++;
        if (stall_low !== 3) begin n_err++; $display("FAIL bp_stall_ready_low: got %0d want 3", stall_low); end
    endtask

    task automatic test_no_terminate();
        logic [1:0] exp_d [4] = '{2'b11, 2'b01, 2'b11, 2'b01};
        logic [3:0] exp_l = 4'b1010;
        do_reset();
        drive_collect(2, 16'h000F, 16'h000A, 4, -1, 0, 4);
        n_vec++;
        if (cap_d.size() !== 4) begin
            n_err++; $display("FAIL noterm_beats: got %0d want 4", cap_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (cap_d[i] !== exp_d[i]) begin n_err++; $display("FAIL noterm_data[%0d]: got %b want %b", i, cap_d[i], exp_d[i]); end
                n_vec++;
                if (cap_l[i] !== exp_l[i]) begin n_err++; $display("FAIL noterm_last[%0d]: got %b want %b", i, cap_l[i], exp_l[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_tail();
        logic [1:0] exp_d [3] = '{2'b11, 2'b10, 2'b11};
        logic [2:0] exp_l = 3'b100;
        do_reset();
        drive_collect(0, 16'h000D, 16'h0008, 4, -1, 0, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (vld[0] !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", vld[0]); end
        n_vec++;
        if (dat[0] !== 2'b00) begin n_err++; $display("FAIL midrst_data: got %b want 00", dat[0]); end
        n_vec++;
        if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", rdy[0]); end
        @(negedge clk);
        drive_collect(0, 16'h0001, 16'h0001, 1, -1, 0, 3);
        n_vec++;
        if (cap_d.size() !== 3) begin
            n_err++; $display("FAIL midrst_beats: got %0d want 3", cap_d.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (cap_d[i] !== exp_d[i]) begin n_err++; $display("FAIL midrst_data[%0d]: got %b want %b", i, cap_d[i], exp_d[i]); end
                n_vec++;
                if (cap_l[i] !== exp_l[i]) begin n_err++; $display("FAIL midrst_last[%0d]: got %b want %b", i, cap_l[i], exp_l[i]); end
            end
        end
    endtask

    task automatic test_k4();
        logic [1:0] exp_d [4] = '{2'b11, 2'b10, 2'b01, 2'b11};
        logic [3:0] exp_l = 4'b1000;
        do_reset();
        drive_collect(3, 16'h0001, 16'h0001, 1, -1, 0, 4);
        n_vec++;
        if (cap_d.size() !== 4) begin
            n_err++; $display("FAIL k4_beats: got %0d want 4", cap_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (cap_d[i] !== exp_d[i]) begin n_err++; $display("FAIL k4_data[%0d]: got %b want %b", i, cap_d[i], exp_d[i]); end
                n_vec++;
                if (cap_l[i] !== exp_l[i]) begin n_err++; $display("FAIL k4_last[%0d]: got %b want %b", i, cap_l[i], exp_l[i]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        test_reset();
        test_ff_terminate();
        test_rsc();
        test_backpressure();
        test_no_terminate();
        test_reset_mid_tail();
        test_k4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_encoder_param.md
Name: conv_encoder_param

Overview:
Parametrised rate-1/2 convolutional encoder. Successor to the fixed 3-bit-state encoder.
- Generalised in constraint length and generator polynomials.
- Selectable feedforward (non-systematic) or recursive systematic (RSC) mode.
- Optional zero-state trellis termination (tail flush) per frame.
- Valid/ready handshakes on both sides, with frame delimiting via last.
- Sits between the bit source and the channel/puncturing stage of the encoder datapath.

Parameters:
- K, 3, constraint length; shift register holds K-1 bits; legal range 3..9.
- G0, 3'b111, generator 0, K bits. Bit i taps delay D^i (bit 0 = current bit). In RSC mode it is the feedback polynomial, and G0[0] must be 1.
- G1, 3'b101, generator 1 (parity polynomial in RSC mode), K bits.
- RECURSIVE, 0, 0 = feedforward, 1 = RSC.
- TERMINATE, 1, 1 = append K-1 tail beats after in_last; 0 = no tail.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input bit valid
- in_ready  output  1  encoder accepts input this cycle
- in_data  input  1  information bit
- in_last  input  1  final information bit of frame
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts output
- out_data  output  2  coded pair {c1,c0}
- out_last  output  1  final coded pair of frame

Behaviour:
- Register r[0..K-2], with r[0] the most recent. Tap vector v[0]=x, v[i]=r[i-1] for i in 1..K-1. P(G) is the XOR over i of G[i]&v[i].
- Feedforward mode:
  - x = in_data.
  - c1 = P(G0), c0 = P(G1).
- RSC mode:
  - fb = XOR over i>=1 of G0[i]&v[i].
  - x = in_data^fb.
  - c1 = in_data (systematic), c0 = P(G1) using v[0]=x.
- On each advancing beat, r <= {r[K-3:0], x}, i.e. r[0] <= x and shift.
- adv = !out_valid || out_ready. Output register loads only when adv. While out_valid && !out_ready, out_data and out_last are held stable.
- States:
  - RUN: in_ready = adv.
    - Accept (in_valid && in_ready) → load output register, update r.
    - Accepted in_last with TERMINATE=1 → TAIL, tail_cnt=0, out_last=0 on that beat.
    - Accepted in_last with TERMINATE=0 → out_last=1 on that beat; r cleared to 0 for the next frame.
  - TAIL: in_ready = 0. On each adv, emit one tail beat:
    - Tail input is 0 (feedforward) or fb (RSC), so x=0. The systematic output reports the tail input.
    - Increment tail_cnt.
    - On beat K-2 (the (K-1)th tail beat), out_last=1, r becomes all zero, and state returns to RUN.
- Latency: one cycle from accept to out_valid. Full throughput: one beat per cycle when out_ready=1.
- in_valid low in RUN: no state change. If adv, out_valid drops to 0.
- rst (any state, mid-frame or mid-tail):
  - State = RUN, r = 0, tail_cnt = 0.
  - out_valid = 0, out_data = 2'b00, out_last = 0.
  - in_ready = 1 in the cycle after rst deasserts.
- out_data is don't-care when out_valid=0, but is driven 2'b00 after reset.
- Elaboration check: fatal if K is out of range, or if RECURSIVE=1 and G0[0]=0.

Decomposition:
- Package conv_enc_pkg holds:
  - typedef enum {RUN, TAIL} enc_state_t.
  - Function poly_xor(g, v) returning the parity of g&v.
  - Default polynomial constants G_7=3'b111 and G_5=3'b101.
- One sub-module, conv_enc_core: combinational next-state and output logic from (r, x-source, mode).
- The top level owns the FSM, tail counter, and output register/handshake.

Test Plan:
1. Defaults (K=3, 7/5, FF, TERMINATE=1), out_ready=1, in bits 1,0,1,1 with last on the 4th → out_data 11,10,00,01 then tail 01,11. out_last only on the 6th beat. in_ready=0 for 2 cycles.
2. RECURSIVE=1, single bit 1 with in_last → out_data 11,10,11. out_last on the 3rd beat. r returns to 0.
3. Backpressure: scenario 1 with out_ready low for 3 cycles after the 2nd beat → out_data held at 10, in_ready=0 during the stall, and the final sequence is unchanged.
4. TERMINATE=0, two frames of bits 1,1 (last on each 2nd bit) → each frame yields 11,01 with out_last on the 2nd beat. The second frame starts from the zero state and is identical to the first.
5. rst asserted on the 1st tail beat of scenario 1 → next cycle out_valid=0, out_data=00, in_ready=1. A fresh input 1 then yields 11.
6. K=4, G0=4'b1011, G1=4'b1101, FF, single bit 1 with last → out_data 11 then tail 10,01,11. out_last on the 4th beat.
